// File: rtl/morse_symbol_decoder.sv
// Morse key front end: times key presses and gaps in 100 ms ticks, classifies dots and dashes
// and packs them into letter code words. Define MORSE_DEBOUNCE_EN to add a key debouncer.
module morse_symbol_decoder #(
  parameter int DASH_TICKS       = 3,
  parameter int LETTER_GAP_TICKS = 3,
  parameter int CNT_W            = 6
`ifdef MORSE_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_CYCLES  = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       tick_100ms,
  input  logic       key,
  output logic       symbol_valid,
  output logic       symbol_is_dash,
  output logic       letter_done,
  output logic [4:0] letter_code,
  output logic [2:0] letter_len,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DASH_THR = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] GAP_THR  = CNT_W'(LETTER_GAP_TICKS);

  state_t           state;
  logic [1:0]       key_sync;
  logic             key_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             is_dash;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_sync <= '0;
    end else if (!enable) begin
      key_sync <= '0;
    end else begin
      key_sync <= {key_sync[0], key};
    end
  end

`ifdef MORSE_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] db_cnt;
  logic            key_db;

  // The debounced level only follows the synchronizer after a full run of identical samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt <= '0;
      key_db <= 1'b0;
    end else if (!enable) begin
      db_cnt <= '0;
      key_db <= 1'b0;
    end else if (key_sync[1] == key_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt <= '0;
      key_db <= key_sync[1];
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  assign key_s = key_db;
`else
  assign key_s = key_sync[1];
`endif

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign is_dash = (cnt >= DASH_THR);

  // Key level changes are checked before ticks, so an edge always masks a coincident tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      symbol_valid   <= 1'b0;
      symbol_is_dash <= 1'b0;
      letter_done    <= 1'b0;
      letter_code    <= '0;
      letter_len     <= '0;
      overflow       <= 1'b0;
    end else if (!enable) begin
      state          <= IDLE;
      cnt            <= '0;
      symbol_valid   <= 1'b0;
      symbol_is_dash <= 1'b0;
      letter_done    <= 1'b0;
      letter_code    <= '0;
      letter_len     <= '0;
      overflow       <= 1'b0;
    end else begin
      symbol_valid <= 1'b0;
      letter_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (key_s) begin
            state <= PRESS;
            cnt   <= '0;
          end
        end
        PRESS: begin
          if (!key_s) begin
            state          <= GAP;
            cnt            <= '0;
            symbol_valid   <= 1'b1;
            symbol_is_dash <= is_dash;
            if (letter_len < 3'd5) begin
              letter_code[letter_len] <= is_dash;
              letter_len              <= letter_len + 3'd1;
            end else begin
              overflow <= 1'b1;
            end
          end else if (tick_100ms) begin
            cnt <= cnt_inc;
          end
        end
        GAP: begin
          if (key_s) begin
            state <= PRESS;
            cnt   <= '0;
          end else if (tick_100ms) begin
            cnt <= cnt_inc;
            if (cnt_inc >= GAP_THR) begin
              state       <= DONE;
              letter_done <= 1'b1;
            end
          end
        end
        DONE: begin
          letter_code <= '0;
          letter_len  <= '0;
          overflow    <= 1'b0;
          cnt         <= '0;
          state       <= key_s ? PRESS : IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Self-checking bench for morse_symbol_decoder: letter table, corner-case sequences and random
// key/tick traffic compared every cycle against a symbol-queue reference model.
module tb_morse_symbol_decoder;

  localparam int DASH = 3;
  localparam int GAP  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       tick_100ms = 1'b0;
  logic       key = 1'b0;
  logic       symbol_valid;
  logic       symbol_is_dash;
  logic       letter_done;
  logic [4:0] letter_code;
  logic [2:0] letter_len;
  logic       overflow;

  morse_symbol_decoder dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .tick_100ms     (tick_100ms),
    .key            (key),
    .symbol_valid   (symbol_valid),
    .symbol_is_dash (symbol_is_dash),
    .letter_done    (letter_done),
    .letter_code    (letter_code),
    .letter_len     (letter_len),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]      n;
    logic [5:0][6:0] ticks;
    logic [4:0]      code;
    logic [2:0]      len;
    logic            ovf;
  } letter_vec_t;

  letter_vec_t tbl [8];

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  // Reference model: key seen by the decoder is the input two samples ago; a letter is the
  // list of classified symbols, from which code, length and overflow are derived.
  bit kd[$];
  bit m_pressed;
  int m_ticks;
  bit m_syms[$];
  bit m_sv;
  bit m_dash;
  bit m_ld;

  logic       ld_seen;
  logic [4:0] ld_code;
  logic [2:0] ld_len;
  logic       ld_ovf;

  function automatic void model_clear();
    kd.delete();
    kd.push_back(1'b0);
    kd.push_back(1'b0);
    m_pressed = 1'b0;
    m_ticks   = 0;
    m_syms.delete();
    m_sv      = 1'b0;
    m_dash    = 1'b0;
    m_ld      = 1'b0;
  endfunction

  function automatic void model_edge(input bit k, input bit t, input bit en);
    bit ks;
    m_sv = 1'b0;
    if (!en) begin
      model_clear();
      return;
    end
    ks = kd.pop_front();
    kd.push_back(k);
    if (m_ld) begin
      m_ld = 1'b0;
      m_syms.delete();
      m_ticks = 0;
      m_pressed = ks;
    end else if (m_pressed) begin
      if (!ks) begin
        m_sv = 1'b1;
        m_dash = (m_ticks >= DASH);
        m_syms.push_back(m_dash);
        m_pressed = 1'b0;
        m_ticks = 0;
      end else if (t) begin
        m_ticks++;
      end
    end else if (ks) begin
      m_pressed = 1'b1;
      m_ticks = 0;
    end else if (t && m_syms.size() > 0) begin
      m_ticks++;
      if (m_ticks >= GAP) m_ld = 1'b1;
    end
  endfunction

  task automatic check_output();
    logic [4:0] ec;
    logic [2:0] el;
    logic       eo;
    ec = '0;
    el = (m_syms.size() > 5) ? 3'd5 : 3'(m_syms.size());
    for (int i = 0; i < int'(el); i++) ec[i] = m_syms[i];
    eo = (m_syms.size() > 5);
    vectors++;
    if ({symbol_valid, symbol_is_dash, letter_done, letter_code, letter_len, overflow} !==
        {m_sv, m_dash, m_ld, ec, el, eo}) begin
      miscompares++;
      $display("[TB] FAIL model cycle %0d: got sv=%b dash=%b done=%b code=%b len=%0d ovf=%b, expected sv=%b dash=%b done=%b code=%b len=%0d ovf=%b",
               cycle, symbol_valid, symbol_is_dash, letter_done, letter_code, letter_len, overflow,
               m_sv, m_dash, m_ld, ec, el, eo);
    end
    if (letter_done === 1'b1) begin
      ld_seen = 1'b1;
      ld_code = letter_code;
      ld_len  = letter_len;
      ld_ovf  = overflow;
    end
  endtask

  task automatic expect_val(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic expect_zero(input string name);
    expect_val(name, int'({symbol_valid, symbol_is_dash, letter_done, letter_code, letter_len, overflow}), 0);
  endtask

  // One clock: inputs driven on the falling edge, outputs compared on the next falling edge.
  task automatic apply_stimulus(input bit k, input bit t);
    key = k;
    tick_100ms = t;
    @(posedge clk);
    model_edge(k, t, enable);
    cycle++;
    @(negedge clk);
    check_output();
  endtask

  task automatic press(input int ticks);
    repeat (3) apply_stimulus(1'b1, 1'b0);
    for (int i = 0; i < ticks; i++) begin
      apply_stimulus(1'b1, 1'b0);
      apply_stimulus(1'b1, 1'b1);
    end
    repeat (3) apply_stimulus(1'b0, 1'b0);
  endtask

  task automatic close_letter(input string name, input logic [4:0] code, input logic [2:0] len,
                              input logic ovf);
    ld_seen = 1'b0;
    for (int g = 0; g < GAP; g++) begin
      apply_stimulus(1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b1);
    end
    for (int w = 0; w < 4 && !ld_seen; w++) apply_stimulus(1'b0, 1'b0);
    vectors++;
    if (!ld_seen || ld_code !== code || ld_len !== len || ld_ovf !== ovf) begin
      miscompares++;
      $display("[TB] FAIL %s: done=%b code=%b len=%0d ovf=%b, expected done=1 code=%b len=%0d ovf=%b",
               name, ld_seen, ld_code, ld_len, ld_ovf, code, len, ovf);
    end
    if (ld_seen) begin
      apply_stimulus(1'b0, 1'b0);
      expect_val({name, "_cleared"}, int'({letter_code, letter_len, overflow}), 0);
    end
  endtask

  function automatic letter_vec_t mk(input int n, input int t0, input int t1, input int t2,
                                     input int t3, input int t4, input int t5,
                                     input logic [4:0] c, input logic [2:0] l, input logic o);
    letter_vec_t v;
    v.n = 3'(n);
    v.ticks[0] = 7'(t0);
    v.ticks[1] = 7'(t1);
    v.ticks[2] = 7'(t2);
    v.ticks[3] = 7'(t3);
    v.ticks[4] = 7'(t4);
    v.ticks[5] = 7'(t5);
    v.code = c;
    v.len = l;
    v.ovf = o;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tbl[0] = mk(1, 1, 0, 0, 0, 0, 0, 5'b00000, 3'd1, 1'b0);
    tbl[1] = mk(2, 1, 3, 0, 0, 0, 0, 5'b00010, 3'd2, 1'b0);
    tbl[2] = mk(6, 1, 1, 1, 1, 1, 1, 5'b00000, 3'd5, 1'b1);
    tbl[3] = mk(3, 3, 3, 3, 0, 0, 0, 5'b00111, 3'd3, 1'b0);
    tbl[4] = mk(4, 0, 4, 1, 5, 0, 0, 5'b01010, 3'd4, 1'b0);
    tbl[5] = mk(5, 3, 1, 1, 1, 3, 0, 5'b10001, 3'd5, 1'b0);
    tbl[6] = mk(6, 3, 3, 3, 3, 3, 1, 5'b11111, 3'd5, 1'b1);
    tbl[7] = mk(2, 2, 3, 0, 0, 0, 0, 5'b00010, 3'd2, 1'b0);

    ld_seen = 1'b0;
    ld_code = '0;
    ld_len  = '0;
    ld_ovf  = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    expect_zero("reset_state");
    rst = 1'b1;
    enable = 1'b1;

    for (int v = 0; v < 8; v++) begin
      for (int s = 0; s < int'(tbl[v].n); s++) begin
        press(int'(tbl[v].ticks[s]));
        if (s < int'(tbl[v].n) - 1) apply_stimulus(1'b0, 1'b1);
      end
      close_letter($sformatf("table_%0d", v), tbl[v].code, tbl[v].len, tbl[v].ovf);
    end

    // Release on the same clock as a tick after two counted ticks: still a dot.
    repeat (3) apply_stimulus(1'b1, 1'b0);
    repeat (2) begin apply_stimulus(1'b1, 1'b0); apply_stimulus(1'b1, 1'b1); end
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1);
    expect_val("release_tick_dot", int'({symbol_valid, symbol_is_dash}), 2);
    close_letter("release_tick_letter", 5'b00000, 3'd1, 1'b0);

    // Same race after three ticks lands exactly on the dash threshold.
    repeat (3) apply_stimulus(1'b1, 1'b0);
    repeat (3) begin apply_stimulus(1'b1, 1'b0); apply_stimulus(1'b1, 1'b1); end
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1);
    expect_val("release_tick_dash", int'({symbol_valid, symbol_is_dash}), 3);
    close_letter("release_tick_dash_letter", 5'b00001, 3'd1, 1'b0);

    // Key rise on the clock the gap would close: the letter continues.
    ld_seen = 1'b0;
    press(1);
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1);
    repeat (3) apply_stimulus(1'b0, 1'b0);
    expect_val("gap_race_no_done", int'(ld_seen), 0);
    close_letter("gap_race_letter", 5'b00000, 3'd2, 1'b0);

    // enable low mid-press with two symbols stored discards the letter.
    press(1);
    apply_stimulus(1'b0, 1'b1);
    press(3);
    apply_stimulus(1'b0, 1'b1);
    repeat (3) apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1);
    expect_val("pre_enable_len", int'(letter_len), 2);
    enable = 1'b0;
    apply_stimulus(1'b1, 1'b0);
    expect_zero("enable_clear");
    enable = 1'b1;
    ld_seen = 1'b0;
    repeat (12) begin apply_stimulus(1'b0, 1'b0); apply_stimulus(1'b0, 1'b1); end
    expect_val("enable_no_done", int'(ld_seen), 0);

    // Asynchronous reset in the middle of a gap.
    press(3);
    apply_stimulus(1'b0, 1'b1);
    #2 rst = 1'b0;
    #1 expect_zero("async_reset");
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    ld_seen = 1'b0;
    repeat (8) begin apply_stimulus(1'b0, 1'b0); apply_stimulus(1'b0, 1'b1); end
    expect_val("reset_no_done", int'(ld_seen), 0);

    // Random key and tick traffic against the model.
    for (int r = 0; r < 150; r++) begin
      bit k;
      int len;
      k = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 30));
      for (int c = 0; c < len; c++) begin
        enable = ($urandom_range(0, 299) != 0);
        apply_stimulus(k, 1'($urandom_range(0, 3) == 0));
      end
    end
    enable = 1'b0;
    apply_stimulus(1'b0, 1'b0);
    enable = 1'b1;

    // Press longer than the counter range stays a dash; a long gap gives one letter_done.
    press(70);
    close_letter("long_dash", 5'b00001, 3'd1, 1'b0);
    ld_seen = 1'b0;
    repeat (20) begin apply_stimulus(1'b0, 1'b0); apply_stimulus(1'b0, 1'b1); end
    expect_val("long_gap_single_done", int'(ld_seen), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
